// File: rtl/kalman_predict_if.sv
// Handshake and data bundle between the predict stage and whoever feeds it.
// The predict stage takes the slave side; the posterior source and the update stage take the master side.
interface kalman_predict_if;
  logic        predict_start_in;
  logic [31:0] gyro_rate_in, angle_in, bias_in;
  logic [31:0] P_0_0_in, P_0_1_in, P_1_0_in, P_1_1_in;
  logic        busy_out, predict_done_out;
  logic [31:0] angle_t_out, bias_t_out;
  logic [31:0] P_0_0_t_out, P_0_1_t_out, P_1_0_t_out, P_1_1_t_out;

  modport master (
    output predict_start_in, gyro_rate_in, angle_in, bias_in,
           P_0_0_in, P_0_1_in, P_1_0_in, P_1_1_in,
    input  busy_out, predict_done_out, angle_t_out, bias_t_out,
           P_0_0_t_out, P_0_1_t_out, P_1_0_t_out, P_1_1_t_out
  );

  modport slave (
    input  predict_start_in, gyro_rate_in, angle_in, bias_in,
           P_0_0_in, P_0_1_in, P_1_0_in, P_1_1_in,
    output busy_out, predict_done_out, angle_t_out, bias_t_out,
           P_0_0_t_out, P_0_1_t_out, P_1_0_t_out, P_1_1_t_out
  );
endinterface

// File: rtl/kalman_predict.sv
// Kalman time-update stage: one Q16.16 prediction of angle/bias/P per start pulse.
// Runs as a fixed 6-state sequence so a single multiplier width covers all products.
module kalman_predict #(
  parameter logic [31:0] DT      = 32'd655,
  parameter logic [31:0] Q_ANGLE = 32'd66,
  parameter logic [31:0] Q_BIAS  = 32'd197
) (
  input  logic             clk_in,
  input  logic             rst_in,
  kalman_predict_if.slave  kp
);

  typedef enum logic [2:0] {IDLE, MUL_A, SUM_A, MUL_B, SUM_B, DONE} state_t;

  typedef struct packed {
    logic [31:0] angle;
    logic [31:0] bias;
    logic [31:0] p00;
    logic [31:0] p01;
    logic [31:0] p10;
    logic [31:0] p11;
  } post_t;

  // Full 64-bit signed product rescaled to Q16.16 by keeping bits [47:16].
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return 32'(p >> 16);
  endfunction

  localparam logic [31:0] QBDT = qmul(Q_BIAS, DT);

  state_t      state_q, state_d;
  post_t       work_q, out_q;
  logic [31:0] gyro_q, pa_q, pb_q, pc_q, t_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kp.predict_start_in) state_d = MUL_A;
      MUL_A:   state_d = SUM_A;
      SUM_A:   state_d = MUL_B;
      MUL_B:   state_d = SUM_B;
      SUM_B:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers are updated in place; outputs only move on the SUM_B edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      work_q <= '0;
      out_q  <= '0;
      gyro_q <= '0;
      pa_q   <= '0;
      pb_q   <= '0;
      pc_q   <= '0;
      t_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (kp.predict_start_in) begin
          gyro_q       <= kp.gyro_rate_in;
          work_q.angle <= kp.angle_in;
          work_q.bias  <= kp.bias_in;
          work_q.p00   <= kp.P_0_0_in;
          work_q.p01   <= kp.P_0_1_in;
          work_q.p10   <= kp.P_1_0_in;
          work_q.p11   <= kp.P_1_1_in;
        end
        MUL_A: begin
          pa_q <= qmul(DT, gyro_q - work_q.bias);
          pb_q <= qmul(DT, work_q.p11);
        end
        SUM_A: begin
          work_q.angle <= work_q.angle + pa_q;
          work_q.p01   <= work_q.p01 - pb_q;
          work_q.p10   <= work_q.p10 - pb_q;
          work_q.p11   <= work_q.p11 + QBDT;
          t_q          <= pb_q - work_q.p01 - work_q.p10 + Q_ANGLE;
        end
        MUL_B: pc_q <= qmul(DT, t_q);
        SUM_B: begin
          out_q.angle <= work_q.angle;
          out_q.bias  <= work_q.bias;
          out_q.p00   <= work_q.p00 + pc_q;
          out_q.p01   <= work_q.p01;
          out_q.p10   <= work_q.p10;
          out_q.p11   <= work_q.p11;
        end
        default: ;
      endcase
    end
  end

  assign kp.busy_out         = (state_q != IDLE);
  assign kp.predict_done_out = (state_q == DONE);
  assign kp.angle_t_out      = out_q.angle;
  assign kp.bias_t_out       = out_q.bias;
  assign kp.P_0_0_t_out      = out_q.p00;
  assign kp.P_0_1_t_out      = out_q.p01;
  assign kp.P_1_0_t_out      = out_q.p10;
  assign kp.P_1_1_t_out      = out_q.p11;

endmodule

// File: tb/tb_kalman_predict.sv
// Bench for kalman_predict: directed timing/boundary cases plus random predictions
// compared against a longint reference of the predict equations.
module tb_kalman_predict;

  localparam logic [31:0] DT      = 32'd655;
  localparam logic [31:0] Q_ANGLE = 32'd66;
  localparam logic [31:0] Q_BIAS  = 32'd197;

  typedef struct {
    logic [31:0] gyro, angle, bias, p00, p01, p10, p11;
  } in_t;

  typedef struct {
    logic [31:0] angle, bias, p00, p01, p10, p11;
  } out_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_cmp = 0;
  int   n_err = 0;

  kalman_predict_if kp();

  kalman_predict dut (.clk_in(clk_in), .rst_in(rst_in), .kp(kp));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Q16.16 product rescaled by arithmetic shift, as plain signed integer math.
  function automatic logic [31:0] qm(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> 16;
    return 32'(p);
  endfunction

  function automatic out_t model(input in_t x);
    out_t        o;
    logic [31:0] pb, t;
    pb      = qm(DT, x.p11);
    t       = pb - x.p01 - x.p10 + Q_ANGLE;
    o.angle = x.angle + qm(DT, x.gyro - x.bias);
    o.bias  = x.bias;
    o.p01   = x.p01 - pb;
    o.p10   = x.p10 - pb;
    o.p11   = x.p11 + qm(Q_BIAS, DT);
    o.p00   = x.p00 + qm(DT, t);
    return o;
  endfunction

  task automatic drive(input in_t x);
    kp.gyro_rate_in = x.gyro;
    kp.angle_in     = x.angle;
    kp.bias_in      = x.bias;
    kp.P_0_0_in     = x.p00;
    kp.P_0_1_in     = x.p01;
    kp.P_1_0_in     = x.p10;
    kp.P_1_1_in     = x.p11;
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".angle_t"}, kp.angle_t_out, e.angle);
    chk({tag, ".bias_t"},  kp.bias_t_out,  e.bias);
    chk({tag, ".P00_t"},   kp.P_0_0_t_out, e.p00);
    chk({tag, ".P01_t"},   kp.P_0_1_t_out, e.p01);
    chk({tag, ".P10_t"},   kp.P_1_0_t_out, e.p10);
    chk({tag, ".P11_t"},   kp.P_1_1_t_out, e.p11);
  endtask

  // Starts a prediction at the next negedge (cycle 0) and returns at the done cycle.
  task automatic run_op(input in_t x, input string tag);
    int lat;
    lat = 0;
    @(negedge clk_in);
    drive(x);
    kp.predict_start_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      if (i == 1) begin
        kp.predict_start_in = 1'b0;
        chk({tag, ".busy1"}, 32'(kp.busy_out), 32'd1);
      end
      if (kp.predict_done_out) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".busy_done"}, 32'(kp.busy_out), 32'd1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (kp.predict_done_out) n++;
    end
  endtask

  in_t  pos_in, neg_in, b2b_in, rin;
  out_t pos_exp, neg_exp, zero_out, e;
  int   nd, lat, gap;

  initial begin
    pos_in  = '{gyro: 32'h000A0000, angle: 32'h0, bias: 32'h0,
                p00: 32'h00010000, p01: 32'h0, p10: 32'h0, p11: 32'h00010000};
    pos_exp = '{angle: 32'h00001996, bias: 32'h0, p00: 32'h00010007,
                p01: 32'hFFFFFD71, p10: 32'hFFFFFD71, p11: 32'h00010001};
    neg_in  = '{gyro: 32'h0, angle: 32'h0, bias: 32'h00010000,
                p00: 32'h0, p01: 32'h0, p10: 32'h0, p11: 32'h0};
    neg_exp = '{angle: 32'hFFFFFD71, bias: 32'h00010000, p00: 32'h0,
                p01: 32'h0, p10: 32'h0, p11: 32'h00000001};
    zero_out = '{angle: 32'h0, bias: 32'h0, p00: 32'h0, p01: 32'h0, p10: 32'h0, p11: 32'h0};

    // Reset with a start pulse held during it.
    rst_in = 1'b1;
    kp.predict_start_in = 1'b1;
    drive(pos_in);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    kp.predict_start_in = 1'b0;
    check_out("reset", zero_out);
    chk("reset.done", 32'(kp.predict_done_out), 32'd0);
    chk("reset.busy", 32'(kp.busy_out), 32'd0);
    count_dones(8, nd);
    chk("reset.no_done", 32'(nd), 32'd0);

    run_op(pos_in, "pos");
    check_out("pos", pos_exp);
    chk("pos.model_angle", kp.angle_t_out, model(pos_in).angle);
    @(negedge clk_in);
    chk("pos.done_clear", 32'(kp.predict_done_out), 32'd0);
    chk("pos.busy_clear", 32'(kp.busy_out), 32'd0);

    run_op(neg_in, "neg");
    check_out("neg", neg_exp);

    // Busy rejection: inputs change in cycle 1, a second start in cycle 2.
    @(negedge clk_in);
    drive(pos_in);
    kp.predict_start_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_in);
      if (i == 1) begin
        kp.predict_start_in = 1'b0;
        drive(neg_in);
      end
      kp.predict_start_in = (i == 2);
      if (kp.predict_done_out && lat == 0) lat = i;
    end
    chk("busyrej.latency", 32'(lat), 32'd5);
    check_out("busyrej", pos_exp);
    count_dones(6, nd);
    chk("busyrej.extra_done", 32'(nd), 32'd0);

    // Reset mid-operation, asserted in cycle 3.
    @(negedge clk_in);
    drive(neg_in);
    kp.predict_start_in = 1'b1;
    nd = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      kp.predict_start_in = 1'b0;
      if (kp.predict_done_out) nd++;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_out("midrst", zero_out);
    chk("midrst.busy", 32'(kp.busy_out), 32'd0);
    count_dones(8, lat);
    chk("midrst.no_done", 32'(nd + lat), 32'd0);
    check_out("midrst.hold", zero_out);

    // Back-to-back: second start lands exactly in cycle 6.
    run_op(pos_in, "b2b_1");
    check_out("b2b_1", pos_exp);
    b2b_in = '{gyro: 32'h000A0000, angle: 32'h00050000, bias: 32'h000A0000,
               p00: 32'h00020000, p01: 32'h00000100, p10: 32'hFFFF8000, p11: 32'h00030000};
    run_op(b2b_in, "b2b_2");
    chk("b2b_2.angle_lit", kp.angle_t_out, 32'h00050000);
    check_out("b2b_2", model(b2b_in));

    // Random predictions, including full-range values that exercise wraparound.
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) begin
        rin.gyro = $urandom; rin.angle = $urandom; rin.bias = $urandom;
        rin.p00  = $urandom; rin.p01   = $urandom; rin.p10  = $urandom; rin.p11 = $urandom;
      end else begin
        rin.gyro  = 32'($signed($urandom_range(0, 32'h00200000)) - 32'sh00100000);
        rin.bias  = 32'($signed($urandom_range(0, 32'h00020000)) - 32'sh00010000);
        rin.angle = 32'($signed($urandom_range(0, 32'h00B40000)) - 32'sh005A0000);
        rin.p00   = $urandom_range(0, 32'h00040000);
        rin.p01   = 32'($signed($urandom_range(0, 32'h00020000)) - 32'sh00010000);
        rin.p10   = 32'($signed($urandom_range(0, 32'h00020000)) - 32'sh00010000);
        rin.p11   = $urandom_range(0, 32'h00040000);
      end
      e = model(rin);
      run_op(rin, $sformatf("rnd%0d", k));
      check_out($sformatf("rnd%0d", k), e);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        kp.gyro_rate_in = $urandom;
        kp.angle_in     = $urandom;
        repeat (gap) @(negedge clk_in);
        chk($sformatf("rnd%0d.hold_angle", k), kp.angle_t_out, e.angle);
        chk($sformatf("rnd%0d.hold_p00", k), kp.P_0_0_t_out, e.p00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
